// File: rtl/addsub_share_ctrl_if.sv
// Handshake bundle between the requesters and the shared add/sub controller.
interface addsub_share_ctrl_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*64-1:0] req_a;
    logic [NREQ*64-1:0] req_b;
    logic [NREQ-1:0]    req_sub;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ-1:0]    rsp_ready;
    logic [63:0]        rsp_sum;
    logic               rsp_cout;
    logic               rsp_ovf;
    logic               zf;
    logic               sf;
    logic               of;

    modport master (
        output req_valid, req_a, req_b, req_sub, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_ovf, zf, sf, of
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sub, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_ovf, zf, sf, of
    );
endinterface

// File: rtl/addsub_share_ctrl.sv
// Round-robin controller sharing one 64-bit add/sub datapath among NREQ
// requesters. Each op takes IDLE (grant) -> EXEC (compute) -> RESP (hold
// result until the granted requester consumes it).
module addsub_share_ctrl #(
    parameter int NREQ = 2
) (
    input  logic               clk,
    input  logic               rst,
    addsub_share_ctrl_if.slave bus
);
    localparam int PTR_W = (NREQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   gnt_q, gnt_d;
    logic [63:0]        a_q, a_d;
    logic [63:0]        b_q, b_d;
    logic               sub_q, sub_d;
    logic [NREQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [63:0]        sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               zf_q, zf_d;
    logic               sf_q, sf_d;
    logic               of_q, of_d;

    logic [PTR_W-1:0]   sel_idx;
    logic [PTR_W-1:0]   cand;
    logic               sel_found;
    logic [NREQ-1:0]    req_ready_c;
    logic [63:0]        b_eff;
    logic [64:0]        add_full;
    logic               add_ovf;
    logic [63:0]        op_a [NREQ];
    logic [63:0]        op_b [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign op_a[gi] = bus.req_a[64*gi +: 64];
        assign op_b[gi] = bus.req_b[64*gi +: 64];
    end

    // Shared adder: subtraction is a + ~b + 1, so c_out=1 means no borrow.
    always_comb begin
        b_eff    = sub_q ? ~b_q : b_q;
        add_full = {1'b0, a_q} + {1'b0, b_eff} + {64'd0, sub_q};
        add_ovf  = (a_q[63] == b_eff[63]) && (add_full[63] != a_q[63]);
    end

    // Round-robin search starting at rr_ptr and wrapping modulo NREQ.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = PTR_W'((int'(rr_ptr_q) + k) % NREQ);
            if (!sel_found && bus.req_valid[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Grant is combinational and only offered while idle.
    always_comb begin
        req_ready_c = '0;
        if (state_q == IDLE && sel_found) begin
            req_ready_c[sel_idx] = 1'b1;
        end
    end

    // Next-state and next-output computation for the controller FSM.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        a_d         = a_q;
        b_d         = b_q;
        sub_d       = sub_q;
        rsp_valid_d = rsp_valid_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        zf_d        = zf_q;
        sf_d        = sf_q;
        of_d        = of_q;
        case (state_q)
            IDLE: begin
                if (sel_found) begin
                    a_d      = op_a[sel_idx];
                    b_d      = op_b[sel_idx];
                    sub_d    = bus.req_sub[sel_idx];
                    gnt_d    = sel_idx;
                    rr_ptr_d = (sel_idx == PTR_W'(NREQ - 1)) ? '0 : sel_idx + 1'b1;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                sum_d              = add_full[63:0];
                cout_d             = add_full[64];
                ovf_d              = add_ovf;
                zf_d               = (add_full[63:0] == 64'd0);
                sf_d               = add_full[63];
                of_d               = add_ovf;
                rsp_valid_d        = '0;
                rsp_valid_d[gnt_q] = 1'b1;
                state_d            = RESP;
            end
            RESP: begin
                if (bus.rsp_ready[gnt_q]) begin
                    rsp_valid_d = '0;
                    state_d     = IDLE;
                end
            end
            default: begin
                rsp_valid_d = '0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and result registers; reset drops any in-flight op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sub_q       <= 1'b0;
            rsp_valid_q <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zf_q        <= 1'b0;
            sf_q        <= 1'b0;
            of_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sub_q       <= sub_d;
            rsp_valid_q <= rsp_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zf_q        <= zf_d;
            sf_q        <= sf_d;
            of_q        <= of_d;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_cout  = cout_q;
    assign bus.rsp_ovf   = ovf_q;
    assign bus.zf        = zf_q;
    assign bus.sf        = sf_q;
    assign bus.of        = of_q;
endmodule

// File: tb/tb_addsub_share_ctrl.sv
// Scoreboard bench for addsub_share_ctrl: the driver issues ops, the model
// predicts grants, latency, results and flags, the monitor compares.
module tb_addsub_share_ctrl;
    localparam int NREQ = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    addsub_share_ctrl_if #(.NREQ(NREQ)) bus ();
    addsub_share_ctrl #(.NREQ(NREQ)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int          idx;
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        int          acc;
    } exp_t;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    exp_t        sb[$];
    logic [63:0] op_a [NREQ];
    logic [63:0] op_b [NREQ];
    logic        op_sub [NREQ];
    bit          pend [NREQ];
    bit          accepted [NREQ];
    bit          auto_refill [NREQ];
    bit          rand_mode = 0;
    int          rsp_mode = 0;
    bit          busy = 0;
    int          rr_next = 0;
    logic        exp_zf = 0, exp_sf = 0, exp_of = 0;
    bit          fair_chk = 0;
    int          last_acc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference arithmetic from plain integer semantics.
    task automatic computeExpected(input logic [63:0] a, input logic [63:0] b, input logic sub,
                                   output logic [63:0] sum, output logic cout, output logic ovf);
        logic signed [65:0] t;
        logic signed [65:0] w;
        sum = sub ? (a - b) : (a + b);
        cout = sub ? (a >= b) : (({1'b0, a} + {1'b0, b}) > 65'h0_FFFF_FFFF_FFFF_FFFF);
        t = sub ? ($signed({{2{a[63]}}, a}) - $signed({{2{b[63]}}, b}))
                : ($signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b}));
        w = $signed({{2{sum[63]}}, sum});
        ovf = (t != w);
    endtask

    function automatic logic [63:0] pick64();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return 64'd1;
            2: return 64'hFFFF_FFFF_FFFF_FFFF;
            3: return 64'h8000_0000_0000_0000;
            4: return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    task automatic driveBus();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i]        = pend[i];
            bus.req_a[64*i +: 64]   = op_a[i];
            bus.req_b[64*i +: 64]   = op_b[i];
            bus.req_sub[i]          = op_sub[i];
        end
        case (rsp_mode)
            0: bus.rsp_ready = '1;
            1: bus.rsp_ready = NREQ'($urandom());
            default: bus.rsp_ready = '0;
        endcase
    endtask

    task automatic applyStimulus(input int i, input logic [63:0] a, input logic [63:0] b, input logic sub);
        op_a[i]   = a;
        op_b[i]   = b;
        op_sub[i] = sub;
        pend[i]   = 1'b1;
        driveBus();
    endtask

    task automatic newRandomOp(input int i);
        applyStimulus(i, pick64(), pick64(), 1'($urandom_range(0, 1)));
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (accepted[i]) begin
                accepted[i] = 0;
                pend[i]     = 0;
                if (auto_refill[i]) newRandomOp(i);
            end
        end
        if (rand_mode) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) newRandomOp(i);
            end
        end
        driveBus();
    endtask

    task automatic waitDone(input int budget, input string name);
        int  n;
        bit  idle;
        n = 0;
        idle = 0;
        while (!idle && n < budget) begin
            stepCycle();
            n++;
            idle = !busy;
            for (int i = 0; i < NREQ; i++) if (pend[i]) idle = 0;
        end
        if (!idle) begin
            n_cmp++;
            n_err++;
            $display("[TB] FAIL %s timeout: still busy after %0d cycles, expected idle", name, budget);
        end
    endtask

    // Per-cycle monitor: predicts grant, response and flags, and scores them.
    task automatic monitorCycle();
        int              exp_g;
        int              c;
        logic [NREQ-1:0] exp_rr;
        logic [NREQ-1:0] exp_rv;
        logic [63:0]     s;
        logic            co, ov;
        exp_t            e;
        exp_g  = -1;
        exp_rr = '0;
        exp_rv = '0;
        if (!busy) begin
            for (int k = 0; k < NREQ; k++) begin
                c = (rr_next + k) % NREQ;
                if (exp_g < 0 && bus.req_valid[c]) exp_g = c;
            end
        end
        if (exp_g >= 0) exp_rr[exp_g] = 1'b1;
        checkOutput("req_ready", 64'(bus.req_ready), 64'(exp_rr));

        if (sb.size() > 0 && cyc >= sb[0].acc + 2) begin
            exp_rv[sb[0].idx] = 1'b1;
            if (cyc == sb[0].acc + 2) begin
                exp_zf = (sb[0].sum == 64'd0);
                exp_sf = sb[0].sum[63];
                exp_of = sb[0].ovf;
            end
        end
        checkOutput("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rv));
        if (exp_rv != '0) begin
            checkOutput("rsp_sum", bus.rsp_sum, sb[0].sum);
            checkOutput("rsp_cout", 64'(bus.rsp_cout), 64'(sb[0].cout));
            checkOutput("rsp_ovf", 64'(bus.rsp_ovf), 64'(sb[0].ovf));
        end
        checkOutput("zf", 64'(bus.zf), 64'(exp_zf));
        checkOutput("sf", 64'(bus.sf), 64'(exp_sf));
        checkOutput("of", 64'(bus.of), 64'(exp_of));

        if (exp_rv != '0 && bus.rsp_ready[sb[0].idx]) begin
            void'(sb.pop_front());
            busy = 0;
        end

        if (exp_g >= 0) begin
            computeExpected(op_a[exp_g], op_b[exp_g], op_sub[exp_g], s, co, ov);
            e.idx = exp_g; e.sum = s; e.cout = co; e.ovf = ov; e.acc = cyc;
            sb.push_back(e);
            busy = 1;
            rr_next = (exp_g + 1) % NREQ;
            accepted[exp_g] = 1;
            if (fair_chk && last_acc >= 0) checkOutput("grant_interval", 64'(cyc - last_acc), 64'd3);
            last_acc = cyc;
        end
    endtask

    // Sample away from the active edge; the monitor is idle while in reset.
    always @(negedge clk) begin
        if (!rst) monitorCycle();
    end

    // Hard stop if the bench somehow never reaches its summary.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by a randomized soak.
    initial begin
        int n;
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = '0; op_b[i] = '0; op_sub[i] = 0;
            pend[i] = 0; accepted[i] = 0; auto_refill[i] = 0;
        end
        driveBus();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        checkOutput("reset_req_ready", 64'(bus.req_ready), 64'd0);
        checkOutput("reset_rsp_sum", bus.rsp_sum, 64'd0);
        checkOutput("reset_cout", 64'(bus.rsp_cout), 64'd0);
        checkOutput("reset_ovf", 64'(bus.rsp_ovf), 64'd0);
        checkOutput("reset_flags", 64'({bus.zf, bus.sf, bus.of}), 64'd0);
        rst = 1'b0;

        $display("[TB] T1 add");
        applyStimulus(0, 64'h4000_0000_0000_0000, 64'hBFFF_FFFF_FFFF_FFFF, 1'b0);
        waitDone(20, "T1");
        $display("[TB] T2 overflow");
        applyStimulus(0, 64'h4000_0000_0000_0001, 64'h4000_0000_0000_0001, 1'b0);
        waitDone(20, "T2");
        $display("[TB] T3 subtract");
        applyStimulus(0, 64'd5, 64'd7, 1'b1);
        waitDone(20, "T3a");
        applyStimulus(0, 64'd9, 64'd9, 1'b1);
        waitDone(20, "T3b");

        $display("[TB] T4 fairness");
        fair_chk = 1; last_acc = -1;
        auto_refill[0] = 1; auto_refill[1] = 1;
        newRandomOp(0); newRandomOp(1);
        repeat (24) stepCycle();
        auto_refill[0] = 0; auto_refill[1] = 0;
        waitDone(40, "T4a");
        last_acc = -1;
        auto_refill[1] = 1;
        newRandomOp(1);
        repeat (15) stepCycle();
        auto_refill[1] = 0;
        waitDone(40, "T4b");
        fair_chk = 0;

        $display("[TB] T5 backpressure");
        rsp_mode = 2;
        newRandomOp(0);
        newRandomOp(1);
        repeat (7) stepCycle();
        rsp_mode = 0;
        waitDone(40, "T5");

        $display("[TB] random soak");
        rsp_mode = 1; rand_mode = 1;
        repeat (400) stepCycle();
        rand_mode = 0; rsp_mode = 0;
        waitDone(60, "soak");

        $display("[TB] T6 reset mid-op");
        applyStimulus(0, 64'h4000_0000_0000_0001, 64'h4000_0000_0000_0001, 1'b0);
        waitDone(20, "T6pre");
        newRandomOp(0);
        n = 0;
        while (pend[0] && n < 10) begin
            stepCycle();
            n++;
        end
        if (pend[0]) begin
            n_cmp++;
            n_err++;
            $display("[TB] FAIL T6 grant timeout: no grant within 10 cycles, expected one");
        end
        #2;
        rst = 1'b1;
        #1;
        checkOutput("T6_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        checkOutput("T6_flags", 64'({bus.zf, bus.sf, bus.of}), 64'd0);
        checkOutput("T6_rsp_sum", bus.rsp_sum, 64'd0);
        sb.delete();
        busy = 0; rr_next = 0;
        exp_zf = 0; exp_sf = 0; exp_of = 0;
        for (int i = 0; i < NREQ; i++) accepted[i] = 0;
        newRandomOp(0);
        newRandomOp(1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        waitDone(40, "T6post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
